vertex_xform_sequencer: RTL and testbench

//  Multi-cycle controller for the vertex stage's transform state. Holds the

---
 rtl/vertex_xform_sequencer_pkg.sv | 43 ++++
 rtl/vertex_xform_sequencer_if.sv | 18 +
 rtl/vertex_xform_sequencer_mac16.sv | 30 +++
 rtl/vertex_xform_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_vertex_xform_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vertex_xform_sequencer_pkg.sv
// Shared opcodes, widths, FSM encodings and Q8.8 helpers for the
// vertex transform sequencer.
package vertex_xform_sequencer_pkg;

  localparam int OPCODE_WIDTH = 8;
  localparam int VREG_WIDTH   = 64;
  localparam int DATA_WIDTH   = 16;

  localparam logic [DATA_WIDTH-1:0] Q88_ONE = 16'h0100;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP          = 8'h00,
    OP_SETCOLOR     = 8'h01,
    OP_BEGINPRIM    = 8'h02,
    OP_ENDPRIM      = 8'h03,
    OP_SETVERTEX    = 8'h04,
    OP_LOADIDENTITY = 8'h05,
    OP_TRANSLATE    = 8'h06,
    OP_SCALE        = 8'h07,
    OP_ROTATE       = 8'h08,
    OP_PUSH         = 8'h09,
    OP_POP          = 8'h0A
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_COMMIT = 3'd2,
    ST_XFORM  = 3'd3,
    ST_COPY   = 3'd4
  } state_e;

  // Identity element for row-major index {row, col}.
  function automatic logic [DATA_WIDTH-1:0] ident(input logic [3:0] idx);
    return (idx[3:2] == idx[1:0]) ? Q88_ONE : '0;
  endfunction

  // Q8.8 value aligned to the Q16.16 accumulator.
  function automatic logic signed [31:0] q88_to_acc(input logic [15:0] v);
    return {{8{v[15]}}, v, 8'h00};
  endfunction

endpackage

// File: rtl/vertex_xform_sequencer_if.sv
// Command handshake from decode into the sequencer.
// master = decode (drives command), slave = sequencer (drives O_Ready).
interface vertex_xform_sequencer_if;
  logic                                            I_Valid;
  logic                                            O_Ready;
  logic [vertex_xform_sequencer_pkg::OPCODE_WIDTH-1:0] I_Opcode;
  logic [vertex_xform_sequencer_pkg::VREG_WIDTH-1:0]   I_VRegIn;

  modport master (
    output I_Valid, I_Opcode, I_VRegIn,
    input  O_Ready
  );

  modport slave (
    input  I_Valid, I_Opcode, I_VRegIn,
    output O_Ready
  );
endinterface

// File: rtl/vertex_xform_sequencer_mac16.sv
// Registered signed Q8.8 multiply-accumulate with clear and addend.
// Ports: clk/rst, en_i, clr_i, a_i, b_i, add_i; res_o = Q8.8 of next acc.
module vertex_mac16 (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  input  logic signed [31:0] add_i,
  output logic        [15:0] res_o
);

  logic signed [31:0] acc_q;
  logic signed [31:0] acc_d;
  logic signed [31:0] prod;

  assign prod  = a_i * b_i;
  assign acc_d = (clr_i ? 32'sd0 : acc_q) + prod + add_i;
  assign res_o = acc_d[23:8];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/vertex_xform_sequencer.sv
// Model-matrix state, push/pop stack and vertex transform sequencer.
// Ports: I_CLOCK, I_RESET, I_FRAMESTALL, cmd (slave handshake), vertex/colour/status outs.
module vertex_xform_sequencer
  import vertex_xform_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int MAT_ELEMS   = 16
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_FRAMESTALL,
  vertex_xform_sequencer_if.slave cmd,
  output logic                    O_VValid,
  output logic [VREG_WIDTH-1:0]   O_VOut,
  output logic [VREG_WIDTH-1:0]   O_ColorOut,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic                    O_Overflow,
  output logic                    O_Underflow
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_e                  state_q;
  logic [5:0]              cnt_q;
  logic [15:0]             c_q [MAT_ELEMS];
  logic [15:0]             t_q [MAT_ELEMS];
  logic [15:0]             r_q [MAT_ELEMS];
  logic [15:0]             stk_q [STACK_DEPTH][MAT_ELEMS];
  logic [VREG_WIDTH-1:0]   stkcol_q [STACK_DEPTH];
  logic [SPW-1:0]          sp_q;
  logic                    prim_q;
  logic                    pop_q;
  logic [VREG_WIDTH-1:0]   op_q;
  logic [15:0]             xres_q;
  logic                    vvalid_q;
  logic [VREG_WIDTH-1:0]   vout_q;
  logic [VREG_WIDTH-1:0]   color_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic                    ovf_q;
  logic                    udf_q;

  logic                    mac_en;
  logic                    mac_clr;
  logic signed [15:0]      mac_a;
  logic signed [15:0]      mac_b;
  logic signed [31:0]      mac_add;
  logic [15:0]             mac_res;

  logic [SIW-1:0]          wr_idx;
  logic [SIW-1:0]          rd_idx;
  logic [3:0]              el;
  logic [15:0]             in_x;
  logic [15:0]             in_y;
  logic                    is_mat;

  assign wr_idx = sp_q[SIW-1:0];
  assign rd_idx = SIW'(sp_q - SPW'(1));
  assign el     = cnt_q[3:0];
  assign in_x   = cmd.I_VRegIn[31:16];
  assign in_y   = cmd.I_VRegIn[47:32];
  assign is_mat = (cmd.I_Opcode == OP_TRANSLATE) ||
                  (cmd.I_Opcode == OP_SCALE) ||
                  (cmd.I_Opcode == OP_ROTATE);

  assign cmd.O_Ready = (state_q == ST_IDLE);
  assign O_VValid    = vvalid_q & ~I_FRAMESTALL;
  assign O_VOut      = vout_q;
  assign O_ColorOut  = color_q;
  assign O_Opcode    = opcode_q;
  assign O_Overflow  = ovf_q;
  assign O_Underflow = udf_q;

  // cnt_q = {i, j, k} in MUL; step number in XFORM.
  always_comb begin
    mac_en  = !I_FRAMESTALL &&
              (state_q == ST_MUL || state_q == ST_XFORM);
    mac_clr = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    mac_add = '0;
    if (state_q == ST_MUL) begin
      mac_a   = c_q[{cnt_q[5:4], cnt_q[1:0]}];
      mac_b   = t_q[{cnt_q[1:0], cnt_q[3:2]}];
      mac_clr = (cnt_q[1:0] == 2'd0);
    end else if (state_q == ST_XFORM) begin
      case (cnt_q[2:0])
        3'd0: begin mac_a = c_q[0]; mac_b = op_q[31:16]; mac_clr = 1'b1; end
        3'd1: begin mac_a = c_q[1]; mac_b = op_q[47:32]; end
        3'd2: mac_add = q88_to_acc(c_q[3]);
        3'd3: begin mac_a = c_q[4]; mac_b = op_q[31:16]; mac_clr = 1'b1; end
        3'd4: begin mac_a = c_q[5]; mac_b = op_q[47:32]; end
        3'd5: mac_add = q88_to_acc(c_q[7]);
        default: ;
      endcase
    end
  end

  vertex_mac16 u_mac (
    .clk   (I_CLOCK),
    .rst   (I_RESET),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .add_i (mac_add),
    .res_o (mac_res)
  );

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sp_q     <= '0;
      prim_q   <= 1'b0;
      pop_q    <= 1'b0;
      op_q     <= '0;
      xres_q   <= '0;
      vvalid_q <= 1'b0;
      vout_q   <= '0;
      color_q  <= '0;
      opcode_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      for (int e = 0; e < MAT_ELEMS; e++) begin
        c_q[e] <= ident(4'(e));
        t_q[e] <= ident(4'(e));
        r_q[e] <= '0;
        for (int s = 0; s < STACK_DEPTH; s++) begin
          stk_q[s][e] <= '0;
        end
      end
      for (int s = 0; s < STACK_DEPTH; s++) begin
        stkcol_q[s] <= '0;
      end
    end else if (!I_FRAMESTALL) begin
      vvalid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd.I_Valid) begin
            opcode_q <= cmd.I_Opcode;
            op_q     <= cmd.I_VRegIn;
            cnt_q    <= '0;
            unique case (1'b1)
              is_mat: begin
                for (int e = 0; e < MAT_ELEMS; e++) begin
                  t_q[e] <= ident(4'(e));
                end
                if (cmd.I_Opcode == OP_TRANSLATE) begin
                  t_q[3] <= in_x;
                  t_q[7] <= in_y;
                end else if (cmd.I_Opcode == OP_SCALE) begin
                  t_q[0] <= in_x;
                  t_q[5] <= in_y;
                end else begin
                  t_q[0] <= in_x;
                  t_q[1] <= in_y;
                  t_q[4] <= 16'h0000 - in_y;
                  t_q[5] <= in_x;
                end
                state_q <= ST_MUL;
              end
              (cmd.I_Opcode == OP_SETVERTEX): begin
                if (prim_q) state_q <= ST_XFORM;
              end
              (cmd.I_Opcode == OP_PUSH): begin
                if (sp_q == SPW'(STACK_DEPTH)) begin
                  ovf_q <= 1'b1;
                end else begin
                  pop_q   <= 1'b0;
                  state_q <= ST_COPY;
                end
              end
              (cmd.I_Opcode == OP_POP): begin
                if (sp_q == '0) begin
                  udf_q <= 1'b1;
                end else begin
                  pop_q   <= 1'b1;
                  state_q <= ST_COPY;
                end
              end
              (cmd.I_Opcode == OP_LOADIDENTITY): begin
                for (int e = 0; e < MAT_ELEMS; e++) begin
                  c_q[e] <= ident(4'(e));
                end
                color_q <= '0;
              end
              (cmd.I_Opcode == OP_SETCOLOR): color_q <= cmd.I_VRegIn;
              (cmd.I_Opcode == OP_BEGINPRIM): prim_q <= 1'b1;
              (cmd.I_Opcode == OP_ENDPRIM): prim_q <= 1'b0;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_q[1:0] == 2'd3) r_q[cnt_q[5:2]] <= mac_res;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          for (int e = 0; e < MAT_ELEMS; e++) begin
            c_q[e] <= r_q[e];
          end
          state_q <= ST_IDLE;
        end
        ST_XFORM: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd2) xres_q <= mac_res;
          if (cnt_q == 6'd5) begin
            vout_q   <= {op_q[63:48], mac_res, xres_q, op_q[15:0]};
            vvalid_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_COPY: begin
          if (pop_q) c_q[el] <= stk_q[rd_idx][el];
          else stk_q[wr_idx][el] <= c_q[el];
          cnt_q <= cnt_q + 6'd1;
          if (el == 4'd15) begin
            if (pop_q) begin
              color_q <= stkcol_q[rd_idx];
              sp_q    <= sp_q - SPW'(1);
            end else begin
              stkcol_q[wr_idx] <= color_q;
              sp_q             <= sp_q + SPW'(1);
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_xform_sequencer.sv
// Directed testbench for vertex_xform_sequencer.
// Inputs driven away from the negedge; outputs sampled 1 time unit after it.
module tb_vertex_xform_sequencer;
  import vertex_xform_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        vvalid;
  logic [63:0] vout;
  logic [63:0] color;
  logic [7:0]  opcode;
  logic        ovf;
  logic        udf;
  int          checks = 0;
  int          errors = 0;

  vertex_xform_sequencer_if cmd ();

  vertex_xform_sequencer dut (
    .I_CLOCK      (clk),
    .I_RESET      (rst),
    .I_FRAMESTALL (stall),
    .cmd          (cmd),
    .O_VValid     (vvalid),
    .O_VOut       (vout),
    .O_ColorOut   (color),
    .O_Opcode     (opcode),
    .O_Overflow   (ovf),
    .O_Underflow  (udf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mkv(input logic [15:0] x, input logic [15:0] y);
    return {16'hA5A5, y, x, 16'h5A5A};
  endfunction

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!cmd.O_Ready && n < bound) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (cmd.O_Ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got %b expected 1", cmd.O_Ready);
    end
  endtask

  // Present one command and return 1 time unit after the accepting edge.
  task automatic issue(input logic [7:0] op, input logic [63:0] v);
    wait_ready(200);
    cmd.I_Valid  = 1'b1;
    cmd.I_Opcode = op;
    cmd.I_VRegIn = v;
    @(negedge clk); #1;
    cmd.I_Valid  = 1'b0;
    cmd.I_Opcode = OP_NOP;
    cmd.I_VRegIn = 64'hDEAD_BEEF_1234_5678;
  endtask

  task automatic wait_vtx(input int bound, output logic got, output int n);
    got = 1'b0;
    n = 0;
    while (!got && n < bound) begin
      @(negedge clk); #1; n++;
      got = vvalid;
    end
  endtask

  task automatic check_vertex(input string name, input logic [63:0] exp);
    logic got;
    int   n;
    wait_vtx(20, got, n);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %b expected 1", name, got);
    end
    checks++;
    if (vout !== exp) begin
      errors++;
      $display("FAIL %s_vout: got %h expected %h", name, vout, exp);
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 6", name, n);
    end
    @(negedge clk); #1;
    checks++;
    if (vvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_width: got %b expected 0", name, vvalid);
    end
  endtask

  task automatic check_no_vertex(input string name);
    logic got;
    int   n;
    wait_vtx(20, got, n);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("FAIL %s: got vvalid %b expected 0", name, got);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (cmd.O_Ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: got %b expected 1", cmd.O_Ready);
    end
    checks++;
    if ({vvalid, ovf, udf} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b expected 000", {vvalid, ovf, udf});
    end
    checks++;
    if ({vout, color, opcode} !== '0) begin
      errors++; $display("FAIL rst_data: got %h %h %h expected 0", vout, color, opcode);
    end
  endtask

  task automatic test_identity_xform;
    issue(OP_BEGINPRIM, '0);
    issue(OP_SETVERTEX, mkv(16'h0200, 16'h0300));
    checks++;
    if (opcode !== OP_SETVERTEX) begin
      errors++; $display("FAIL opcode_reg: got %h expected %h", opcode, OP_SETVERTEX);
    end
    check_vertex("ident", mkv(16'h0200, 16'h0300));
  endtask

  task automatic test_translate;
    int n = 0;
    issue(OP_TRANSLATE, mkv(16'h0100, 16'hFF00));
    while (!cmd.O_Ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n != 65) begin
      errors++; $display("FAIL mul_busy: got %0d cycles expected 65", n);
    end
    issue(OP_SETVERTEX, mkv(16'h0200, 16'h0300));
    check_vertex("translate", mkv(16'h0300, 16'h0200));
  endtask

  task automatic test_scale_rotate;
    issue(OP_LOADIDENTITY, '0);
    issue(OP_SCALE, mkv(16'h0200, 16'h0080));
    issue(OP_SETVERTEX, mkv(16'h0100, 16'h0400));
    check_vertex("scale", mkv(16'h0200, 16'h0200));
    issue(OP_LOADIDENTITY, '0);
    issue(OP_ROTATE, mkv(16'h0000, 16'h0100));
    issue(OP_SETVERTEX, mkv(16'h0200, 16'h0300));
    check_vertex("rotate", mkv(16'h0300, 16'hFE00));
  endtask

  task automatic test_stack;
    issue(OP_LOADIDENTITY, '0);
    issue(OP_SETCOLOR, 64'h11);
    issue(OP_PUSH, '0);
    issue(OP_SETCOLOR, 64'h22);
    issue(OP_TRANSLATE, mkv(16'h0500, 16'h0500));
    issue(OP_POP, '0);
    wait_ready(100);
    checks++;
    if (color !== 64'h11) begin
      errors++; $display("FAIL pop_color: got %h expected 11", color);
    end
    issue(OP_SETVERTEX, mkv(16'h0100, 16'h0100));
    check_vertex("push_pop", mkv(16'h0100, 16'h0100));
    for (int i = 0; i < 4; i++) issue(OP_PUSH, '0);
    wait_ready(100);
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_early: got %b expected 0", ovf);
    end
    issue(OP_PUSH, '0);
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", ovf);
    end
    for (int i = 0; i < 4; i++) issue(OP_POP, '0);
    wait_ready(100);
    checks++;
    if (udf !== 1'b0) begin
      errors++; $display("FAIL udf_early: got %b expected 0", udf);
    end
    issue(OP_POP, '0);
    checks++;
    if ({ovf, udf} !== 2'b11) begin
      errors++; $display("FAIL udf_set: got %b expected 11", {ovf, udf});
    end
  endtask

  task automatic test_framestall;
    int n = 0;
    issue(OP_LOADIDENTITY, '0);
    issue(OP_TRANSLATE, mkv(16'h0100, 16'h0200));
    while (!cmd.O_Ready && n < 300) begin
      @(negedge clk); #1; n++;
      if (n == 20) stall = 1'b1;
      if (n == 30) stall = 1'b0;
    end
    checks++;
    if (n != 75) begin
      errors++; $display("FAIL stall_busy: got %0d cycles expected 75", n);
    end
    issue(OP_SETVERTEX, mkv(16'h0000, 16'h0000));
    check_vertex("stall", mkv(16'h0100, 16'h0200));
    issue(OP_ENDPRIM, '0);
    issue(OP_SETVERTEX, mkv(16'h0300, 16'h0300));
    check_no_vertex("no_prim");
  endtask

  task automatic test_reset_mid_xform;
    issue(OP_BEGINPRIM, '0);
    issue(OP_TRANSLATE, mkv(16'h0100, 16'h0100));
    issue(OP_SETVERTEX, mkv(16'h0200, 16'h0300));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd.O_Ready, vvalid, ovf, udf} !== 4'b1000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 1000", {cmd.O_Ready, vvalid, ovf, udf});
    end
    @(posedge clk);
    rst = 1'b0;
    issue(OP_SETVERTEX, mkv(16'h0200, 16'h0300));
    check_no_vertex("reset_prim_clear");
    issue(OP_BEGINPRIM, '0);
    issue(OP_SETVERTEX, mkv(16'h0200, 16'h0300));
    check_vertex("reset_ident", mkv(16'h0200, 16'h0300));
  endtask

  initial begin
    cmd.I_Valid  = 1'b0;
    cmd.I_Opcode = OP_NOP;
    cmd.I_VRegIn = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    #1;
    test_reset;
    test_identity_xform;
    test_translate;
    test_scale_rotate;
    test_stack;
    test_framestall;
    test_reset_mid_xform;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
